// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file and its scoreboard.
// win_port is the single priority rule for resolving colliding write ports.
package rf_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] MEM_DEPTH        = 32'h0001_0000;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'h0100_0000 + MEM_DEPTH;
    localparam int          MAX_PORTS        = 32;

    function automatic int addr_width(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    // Highest-index asserted bit of a port match vector, or -1 when nothing matches.
    function automatic int win_port(input logic [MAX_PORTS-1:0] match);
        int win;
        win = -1;
        for (int p = 0; p < MAX_PORTS; p++) begin
            if (match[p]) begin
                win = p;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for hazard detection.
// Flush beats issue, and issue beats writeback clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic [NWRITE-1:0]     wr_eff,
    input  logic [NWRITE*AW-1:0]  wr_addr,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD-1:0]      rd_busy
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    genvar gi, gj;

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] clear;
    logic             issue_ok;

    assign issue_ok = issue_en && ({1'b0, issue_addr} < NREGS_W)
                      && !(ZERO_REG && (issue_addr == '0));

    for (gi = 0; gi < NREGS; gi++) begin : g_clear
        logic [NWRITE-1:0] hit;
        for (gj = 0; gj < NWRITE; gj++) begin : g_hit
            assign hit[gj] = wr_eff[gj] && (wr_addr[gj*AW +: AW] == AW'(gi));
        end
        assign clear[gi] = (win_port(MAX_PORTS'(hit)) >= 0);
    end

    always_comb begin
        pending_next = pending_reg;
        if (flush) begin
            pending_next = '0;
        end else begin
            pending_next = pending_reg & ~clear;
            if (issue_ok) begin
                pending_next[issue_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // A writeback landing this cycle resolves the hazard early when bypass is on.
    for (gi = 0; gi < NREAD; gi++) begin : g_busy
        logic [AW-1:0]     addr;
        logic              addr_ok;
        logic [NWRITE-1:0] hit;
        assign addr    = rd_addr[gi*AW +: AW];
        assign addr_ok = ({1'b0, addr} < NREGS_W) && !(ZERO_REG && (addr == '0));
        for (gj = 0; gj < NWRITE; gj++) begin : g_hit
            assign hit[gj] = wr_eff[gj] && (wr_addr[gj*AW +: AW] == addr);
        end
        assign rd_busy[gi] = addr_ok && pending_reg[addr]
                             && !(BYPASS && (win_port(MAX_PORTS'(hit)) >= 0));
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port integer register file with prioritised writes, same-cycle bypass
// and a pending scoreboard feeding the decode-stage stall logic.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter int               NREGS    = 32,
    parameter int               NREAD    = 2,
    parameter int               NWRITE   = 2,
    parameter int               SP_INDEX = 2,
    parameter logic [XLEN-1:0]  SP_RESET = XLEN'(SP_RESET_DEFAULT),
    parameter bit               ZERO_REG = 1'b1,
    parameter bit               BYPASS   = 1'b1,
    localparam int              AW       = addr_width(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr,
    input  logic                    flush
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    genvar gi, gj;

    logic [AW-1:0]     wr_addr_a [NWRITE];
    logic [XLEN-1:0]   wr_data_a [NWRITE];
    logic [NWRITE-1:0] wr_eff;
    logic [XLEN-1:0]   regs_reg  [NREGS];
    logic [NREGS-1:0]  reg_we;
    logic [XLEN-1:0]   reg_wdata [NREGS];

    // A write is effective only for an in-range address that is not the hardwired zero.
    for (gi = 0; gi < NWRITE; gi++) begin : g_wport
        assign wr_addr_a[gi] = wr_addr[gi*AW +: AW];
        assign wr_data_a[gi] = wr_data[gi*XLEN +: XLEN];
        assign wr_eff[gi]    = wr_en[gi] && ({1'b0, wr_addr_a[gi]} < NREGS_W)
                               && !(ZERO_REG && (wr_addr_a[gi] == '0));
    end

    for (gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [NWRITE-1:0] hit;
        int                win;
        logic [XLEN-1:0]   wdata;
        for (gj = 0; gj < NWRITE; gj++) begin : g_hit
            assign hit[gj] = wr_eff[gj] && (wr_addr_a[gj] == AW'(gi));
        end
        assign win = win_port(MAX_PORTS'(hit));
        always_comb begin
            wdata = '0;
            for (int w = 0; w < NWRITE; w++) begin
                if (w == win) begin
                    wdata = wr_data_a[w];
                end
            end
        end
        assign reg_we[gi]    = (win >= 0);
        assign reg_wdata[gi] = wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= reg_wdata[i];
                end
            end
        end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_rport
        logic [AW-1:0]     addr;
        logic              addr_ok;
        logic [NWRITE-1:0] hit;
        int                win;
        logic [XLEN-1:0]   fwd;
        logic [XLEN-1:0]   stored;
        assign addr    = rd_addr[gi*AW +: AW];
        assign addr_ok = ({1'b0, addr} < NREGS_W) && !(ZERO_REG && (addr == '0));
        for (gj = 0; gj < NWRITE; gj++) begin : g_hit
            assign hit[gj] = wr_eff[gj] && (wr_addr_a[gj] == addr);
        end
        assign win = win_port(MAX_PORTS'(hit));
        always_comb begin
            fwd = '0;
            for (int w = 0; w < NWRITE; w++) begin
                if (w == win) begin
                    fwd = wr_data_a[w];
                end
            end
        end
        assign stored = addr_ok ? regs_reg[addr] : '0;
        assign rd_data[gi*XLEN +: XLEN] = !addr_ok                  ? '0  :
                                          (BYPASS && (win >= 0))    ? fwd : stored;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_eff     (wr_eff),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Two register files share one stimulus bus: A (16 regs, zero reg, bypass) and
// B (12 regs, no zero reg, no bypass); both are scored against a behavioural model.
module tb_multiport_register_file;

    localparam int XL = 64;
    localparam int NR = 4;
    localparam int NW = 3;
    localparam int AW = 4;
    localparam logic [XL-1:0] SP_VAL = 64'h0100_0000 + 64'(rf_pkg::MEM_DEPTH);

    typedef struct {
        logic [NR*XL-1:0] data_a;
        logic [NR-1:0]    busy_a;
        logic [NR*XL-1:0] data_b;
        logic [NR-1:0]    busy_b;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*XL-1:0] wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             flush;
    logic [NR*XL-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_busy_a, rd_busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    int nregs_c [2] = '{16, 12};
    bit zero_c  [2] = '{1'b1, 1'b0};
    bit byp_c   [2] = '{1'b1, 1'b0};
    logic [XL-1:0] m_regs [2][16];
    bit            m_pend [2][16];

    always #5 clock = ~clock;

    multiport_register_file #(
        .XLEN(XL), .NREGS(16), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
    );

    multiport_register_file #(
        .XLEN(XL), .NREGS(12), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
    );

    task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NR*AW-1:0] ra4(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NW*AW-1:0] wa3(input int a0, input int a1, input int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NW*XL-1:0] wd3(input logic [XL-1:0] d0, input logic [XL-1:0] d1,
                                             input logic [XL-1:0] d2);
        return {d2, d1, d0};
    endfunction

    function automatic logic [XL-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[c][i] = (i == 2) ? SP_VAL : '0;
                m_pend[c][i] = 1'b0;
            end
        end
    endtask

    function automatic bit usable(input int c, input int a);
        return (a < nregs_c[c]) && !(zero_c[c] && a == 0);
    endfunction

    // Expected outputs for this cycle's inputs, then the state seen after the edge.
    task automatic model_step(input int c, output logic [NR*XL-1:0] d, output logic [NR-1:0] b);
        int a;
        int wa;
        d = '0;
        b = '0;
        for (int r = 0; r < NR; r++) begin
            a = int'(rd_addr[r*AW +: AW]);
            if (usable(c, a)) begin
                d[r*XL +: XL] = m_regs[c][a];
                b[r] = m_pend[c][a];
                if (byp_c[c]) begin
                    for (int w = 0; w < NW; w++) begin
                        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
                            d[r*XL +: XL] = wr_data[w*XL +: XL];
                            b[r] = 1'b0;
                        end
                    end
                end
            end
        end
        for (int w = 0; w < NW; w++) begin
            wa = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && usable(c, wa)) begin
                m_regs[c][wa] = wr_data[w*XL +: XL];
                if (!flush) m_pend[c][wa] = 1'b0;
            end
        end
        if (flush) begin
            for (int i = 0; i < 16; i++) m_pend[c][i] = 1'b0;
        end else if (issue_en && usable(c, int'(issue_addr))) begin
            m_pend[c][int'(issue_addr)] = 1'b1;
        end
    endtask

    task automatic cycle(input logic [NW-1:0] en, input logic [NW*AW-1:0] wa,
                         input logic [NW*XL-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                         input logic fl, input logic [NR*AW-1:0] ra);
        exp_t e;
        @(posedge clock);
        #1;
        wr_en = en; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; flush = fl; rd_addr = ra;
        model_step(0, e.data_a, e.busy_a);
        model_step(1, e.data_b, e.busy_b);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [NR*AW-1:0] ra);
        cycle('0, '0, '0, 1'b0, '0, 1'b0, ra);
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " A x2"}, rd_data_a[0 +: XL], SP_VAL);
        chk({tag, " A x5"}, rd_data_a[XL +: XL], '0);
        chk({tag, " B x2"}, rd_data_b[0 +: XL], SP_VAL);
        chk({tag, " B x5"}, rd_data_b[XL +: XL], '0);
        chk({tag, " A busy"}, XL'(rd_busy_a), '0);
        chk({tag, " B busy"}, XL'(rd_busy_b), '0);
    endtask

    // Monitor: every mid-cycle, score the outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int r = 0; r < NR; r++) begin
                    chk($sformatf("A rd_data[%0d]", r), rd_data_a[r*XL +: XL], e.data_a[r*XL +: XL]);
                    chk($sformatf("B rd_data[%0d]", r), rd_data_b[r*XL +: XL], e.data_b[r*XL +: XL]);
                end
                chk("A rd_busy", XL'(rd_busy_a), XL'(e.busy_a));
                chk("B rd_busy", XL'(rd_busy_b), XL'(e.busy_b));
            end
        end
    end

    initial begin
        logic [XL-1:0] d9;
        reset_n = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        idle(ra4(2, 5, 0, 1));
        mid();
        check_reset_state("post-reset");

        // Both low ports hit x7; port 1 wins.
        cycle(3'b011, wa3(7, 7, 0), wd3(64'hAAAA_0000, 64'h5555_1111, '0), 1'b0, '0, 1'b0, ra4(7, 7, 0, 0));
        mid();
        chk("bypass x7 A", rd_data_a[0 +: XL], 64'h5555_1111);
        chk("no-bypass x7 B", rd_data_b[0 +: XL], '0);
        idle(ra4(7, 0, 0, 0));
        mid();
        chk("x7 A", rd_data_a[0 +: XL], 64'h5555_1111);
        chk("x7 B", rd_data_b[0 +: XL], 64'h5555_1111);

        cycle(3'b001, wa3(0, 0, 0), wd3(64'hDEAD_BEEF, '0, '0), 1'b1, AW'(0), 1'b0, ra4(0, 0, 0, 0));
        mid();
        chk("x0 same-cycle A", rd_data_a[0 +: XL], '0);
        idle(ra4(0, 0, 0, 0));
        mid();
        chk("x0 A", rd_data_a[0 +: XL], '0);
        chk("x0 busy A", XL'(rd_busy_a[0]), '0);
        chk("x0 B", rd_data_b[0 +: XL], 64'hDEAD_BEEF);
        chk("x0 busy B", XL'(rd_busy_b[0]), 64'd1);

        d9 = rnd64();
        cycle('0, '0, '0, 1'b1, AW'(9), 1'b0, ra4(9, 0, 0, 0));
        mid();
        chk("x9 busy c0 A", XL'(rd_busy_a[0]), '0);
        idle(ra4(9, 0, 0, 0));
        mid();
        chk("x9 busy c1 A", XL'(rd_busy_a[0]), 64'd1);
        chk("x9 busy c1 B", XL'(rd_busy_b[0]), 64'd1);
        idle(ra4(9, 0, 0, 0));
        cycle(3'b010, wa3(0, 9, 0), wd3('0, d9, '0), 1'b0, '0, 1'b0, ra4(9, 0, 0, 0));
        mid();
        chk("x9 busy c3 A", XL'(rd_busy_a[0]), '0);
        chk("x9 busy c3 B", XL'(rd_busy_b[0]), 64'd1);
        idle(ra4(9, 0, 0, 0));
        mid();
        chk("x9 busy c4 B", XL'(rd_busy_b[0]), '0);
        chk("x9 data c4 B", rd_data_b[0 +: XL], d9);

        cycle(3'b100, wa3(0, 0, 4), wd3('0, '0, rnd64()), 1'b1, AW'(4), 1'b0, ra4(4, 0, 0, 0));
        cycle('0, '0, '0, 1'b1, AW'(6), 1'b1, ra4(4, 6, 0, 0));
        mid();
        chk("x4 busy after issue+write A", XL'(rd_busy_a[0]), 64'd1);
        chk("x4 busy after issue+write B", XL'(rd_busy_b[0]), 64'd1);
        idle(ra4(4, 6, 0, 0));
        mid();
        chk("busy after flush A", XL'(rd_busy_a), '0);
        chk("busy after flush B", XL'(rd_busy_b), '0);

        cycle(3'b001, wa3(13, 0, 0), wd3(64'h1234_5678_9ABC_DEF0, '0, '0), 1'b1, AW'(13), 1'b0, ra4(13, 0, 0, 0));
        idle(ra4(13, 0, 0, 0));
        mid();
        chk("x13 A", rd_data_a[0 +: XL], 64'h1234_5678_9ABC_DEF0);
        chk("x13 busy A", XL'(rd_busy_a[0]), 64'd1);
        chk("x13 B out of range", rd_data_b[0 +: XL], '0);
        chk("x13 busy B out of range", XL'(rd_busy_b[0]), '0);

        // Asynchronous reset mid-cycle with live state in x2/x5.
        cycle(3'b011, wa3(2, 5, 0), wd3(rnd64(), rnd64(), '0), 1'b1, AW'(5), 1'b0, ra4(2, 5, 0, 0));
        idle(ra4(2, 5, 0, 0));
        mid();
        #1;
        reset_n = 1'b0;
        wr_en = '0; issue_en = 1'b0; flush = 1'b0;
        #1;
        check_reset_state("async reset");
        model_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            cycle(NW'($urandom), (NW*AW)'($urandom),
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) == 0), AW'($urandom), ($urandom_range(0, 31) == 0),
                  (NR*AW)'($urandom));
        end
        idle('0);

        repeat (3) @(negedge clock);
        #1;
        chk("scoreboard drained", XL'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
